btn_debounce: RTL and testbench
===============================

// Module: btn_debounce
// PURPOSE
//   Input-side counterpart to the LED blinker: reads the board push-buttons that drive the
//   LED demo and turns raw, bouncing pins into clean per-button events.
//   Each button gets a 2-flop synchronizer, a debounce counter and a hold-time FSM. The block
//   emits a debounced level plus single-cycle press, release, click (short) and long-press pulses.
//   Sits between the board pins and the fabric LED/control logic, on the 1 MHz fabric clock.
// PARAMETERS
//   N_BTN            2        number of independent buttons
//   DEBOUNCE_CYCLES  10000    consecutive stable cycles needed to accept a change (10 ms @ 1 MHz); must be >= 2
//   LONG_CYCLES      1000000  cycles o_level must stay high before o_long fires (1 s @ 1 MHz); must be >= 1
//   ACTIVE_LOW       1        1: pin low = pressed; 0: pin high = pressed
// PORTS
//   clk        in   1      fabric clock; everything is on posedge clk
//   reset      in   1      synchronous, active-high reset
//   i_btn      in   N_BTN  raw asynchronous button pins
//   o_level    out  N_BTN  debounced pressed state (1 = pressed)
//   o_press    out  N_BTN  1-cycle pulse when o_level rises
//   o_release  out  N_BTN  1-cycle pulse when o_level falls
//   o_click    out  N_BTN  1-cycle pulse on release when o_long did not fire during the hold
//   o_long     out  N_BTN  1-cycle pulse after LONG_CYCLES cycles held; at most once per press
// BEHAVIOUR
//   Reset: one clock; reset is synchronous and active-high. Ports are clk and reset.
//   - While reset=1, all outputs = 0, all counters = 0, FSMs = IDLE.
//   - Synchronizer flops load the inactive pin level (ACTIVE_LOW ? 1 : 0).
//   Sync: 2 flops per bit. act = ACTIVE_LOW ? ~sync : sync.
//   Debounce, per button:
//   - dcnt clears whenever act == o_level and increments while act != o_level.
//   - When act != o_level and dcnt == DEBOUNCE_CYCLES-1: o_level toggles next edge and dcnt clears.
//   - Latency: o_level changes DEBOUNCE_CYCLES+2 edges after the first edge that samples the new pin level.
//   - Any return to the old level before that point clears dcnt, so no change occurs (glitch rejected).
//   FSM, per button, driven by o_level edges:
//   - IDLE: o_level rising -> HELD. o_press=1 that same cycle. hcnt=1.
//   - HELD: hcnt increments each cycle while o_level=1.
//     - hcnt == LONG_CYCLES -> LONG. o_long=1 for one cycle.
//     - o_level falling -> IDLE. o_release=1 and o_click=1 in the same cycle.
//   - LONG: hcnt holds (saturates) and o_long does not repeat.
//     - o_level falling -> IDLE. o_release=1, o_click=0.
//   Pulse timing and widths:
//   - All pulses are registered and coincide with the first cycle of the new o_level value.
//   - o_long fires exactly LONG_CYCLES cycles after o_press.
//   - hcnt width = $clog2(LONG_CYCLES+1). dcnt width = $clog2(DEBOUNCE_CYCLES). Neither counter wraps.
//   Boundaries:
//   - Buttons are fully independent; simultaneous events on different bits are all reported in the same cycle.
//   - If the hold would end in the very cycle o_long would fire: release takes priority, o_long is suppressed, o_click=1.
//   - Reset mid-press clears all state. A button still held afterwards is reported as a new press
//     DEBOUNCE_CYCLES+2 cycles after reset deasserts.
//   - Every asserted pulse bit is exactly one cycle wide.
// TESTING (DEBOUNCE_CYCLES=4, LONG_CYCLES=20, ACTIVE_LOW=1, N_BTN=2)
//   1 reset=1 for 3 cycles with i_btn=2'b00 (both pressed) -> all outputs 0 during reset;
//     o_level=2'b11 and o_press=2'b11 exactly 6 cycles after reset falls.
//   2 i_btn[0] 1->0 clean -> o_level[0] rises 6 edges later with a 1-cycle o_press[0];
//     i_btn[1] outputs stay 0.
//   3 i_btn[0] toggles low 3 cycles / high 1 cycle, repeated 10 times -> o_level[0] never changes
//     and no pulses occur.
//   4 hold i_btn[0] low 10 debounced cycles, then release -> o_press, then o_release+o_click
//     together; o_long never fires.
//   5 hold i_btn[1] low 30 cycles -> o_long[1] exactly 20 cycles after o_press[1], once only;
//     release -> o_release[1] with o_click[1]=0.
//   6 press both, reset asserted mid-hold at hcnt=10 -> outputs 0 next edge; with pins still low,
//     new o_press=2'b11 6 cycles after reset falls; no o_long leftover from the old hold.

Source files
------------

// File: rtl/btn_debounce.sv
// Per-button synchronizer, debounce counter and hold-time FSM.
// Produces a clean pressed level plus press/release/click/long one-cycle pulses.
module btn_debounce #(
  parameter int N_BTN           = 2,
  parameter int DEBOUNCE_CYCLES = 10000,
  parameter int LONG_CYCLES     = 1000000,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] i_btn,
  output logic [N_BTN-1:0] o_level,
  output logic [N_BTN-1:0] o_press,
  output logic [N_BTN-1:0] o_release,
  output logic [N_BTN-1:0] o_click,
  output logic [N_BTN-1:0] o_long
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int HW = $clog2(LONG_CYCLES + 1);
  localparam logic INACTIVE = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

  typedef enum logic [1:0] {IDLE, HELD, LONG} state_t;

  logic [N_BTN-1:0] sync1_q, sync2_q, act;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= {N_BTN{INACTIVE}};
      sync2_q <= {N_BTN{INACTIVE}};
    end else begin
      sync1_q <= i_btn;
      sync2_q <= sync1_q;
    end
  end

  assign act = (ACTIVE_LOW != 0) ? ~sync2_q : sync2_q;

  generate
    for (genvar gi = 0; gi < N_BTN; gi++) begin : g_btn
      logic [DW-1:0] dcnt_q, dcnt_d;
      logic [HW-1:0] hcnt_q, hcnt_d;
      logic          level_q, level_d;
      state_t        state_q, state_d;
      logic          press_q, press_d, release_q, release_d;
      logic          click_q, click_d, long_q, long_d;

      always_comb begin
        level_d   = level_q;
        dcnt_d    = '0;
        state_d   = state_q;
        hcnt_d    = hcnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        click_d   = 1'b0;
        long_d    = 1'b0;

        if (act[gi] != level_q) begin
          if (dcnt_q == DW'(DEBOUNCE_CYCLES - 1)) begin
            level_d = ~level_q;
          end else begin
            dcnt_d = dcnt_q + DW'(1);
          end
        end

        // FSM reacts to the next level so pulses land with the new level value
        case (state_q)
          IDLE: begin
            if (level_d) begin
              state_d = HELD;
              hcnt_d  = HW'(1);
              press_d = 1'b1;
            end
          end
          HELD: begin
            if (!level_d) begin
              state_d   = IDLE;
              hcnt_d    = '0;
              release_d = 1'b1;
              click_d   = 1'b1;
            end else if (hcnt_q == HW'(LONG_CYCLES)) begin
              state_d = LONG;
              long_d  = 1'b1;
            end else begin
              hcnt_d = hcnt_q + HW'(1);
            end
          end
          LONG: begin
            if (!level_d) begin
              state_d   = IDLE;
              hcnt_d    = '0;
              release_d = 1'b1;
            end
          end
          default: begin
            state_d = IDLE;
            hcnt_d  = '0;
          end
        endcase
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          dcnt_q    <= '0;
          hcnt_q    <= '0;
          level_q   <= 1'b0;
          state_q   <= IDLE;
          press_q   <= 1'b0;
          release_q <= 1'b0;
          click_q   <= 1'b0;
          long_q    <= 1'b0;
        end else begin
          dcnt_q    <= dcnt_d;
          hcnt_q    <= hcnt_d;
          level_q   <= level_d;
          state_q   <= state_d;
          press_q   <= press_d;
          release_q <= release_d;
          click_q   <= click_d;
          long_q    <= long_d;
        end
      end

      assign o_level[gi]   = level_q;
      assign o_press[gi]   = press_q;
      assign o_release[gi] = release_q;
      assign o_click[gi]   = click_q;
      assign o_long[gi]    = long_q;
    end
  endgenerate

endmodule

// File: tb/tb_btn_debounce.sv
// Bench for btn_debounce: vector table, directed corner sequences and random
// pin activity, all checked against a timestamp-based reference model.
module tb_btn_debounce;
  localparam int N = 2;
  localparam int D = 4;
  localparam int L = 20;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] i_btn;
  logic [1:0] o_level, o_press, o_release, o_click, o_long;

  always #5 clk = ~clk;

  btn_debounce #(.N_BTN(N), .DEBOUNCE_CYCLES(D), .LONG_CYCLES(L), .ACTIVE_LOW(1)) dut (
    .clk(clk), .reset(reset), .i_btn(i_btn),
    .o_level(o_level), .o_press(o_press), .o_release(o_release),
    .o_click(o_click), .o_long(o_long)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: pin history for the 2-cycle sync delay, a run length of
  // disagreeing samples, and press timestamps for the hold measurement.
  logic [1:0] h1, h2, m_lvl;
  logic [1:0] e_prs, e_rel, e_clk, e_lng;
  int  run [2];
  int  t0  [2];
  bit  ldone [2];
  int  cyc = 0;

  task automatic check(input string name, input logic [9:0] got, input logic [9:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic model_step(input logic r, input logic [1:0] b);
    if (r) begin
      h1 = 2'b11; h2 = 2'b11; m_lvl = 2'b00;
      e_prs = 0; e_rel = 0; e_clk = 0; e_lng = 0;
      for (int k = 0; k < 2; k++) begin run[k] = 0; ldone[k] = 0; t0[k] = 0; end
    end else begin
      for (int k = 0; k < 2; k++) begin
        logic a, nl;
        a  = ~h2[k];
        nl = m_lvl[k];
        if (a != m_lvl[k]) begin
          run[k]++;
          if (run[k] == D) begin nl = ~m_lvl[k]; run[k] = 0; end
        end else begin
          run[k] = 0;
        end
        e_prs[k] = nl & ~m_lvl[k];
        e_rel[k] = ~nl & m_lvl[k];
        if (e_prs[k]) begin t0[k] = cyc; ldone[k] = 0; end
        e_lng[k] = nl && m_lvl[k] && !ldone[k] && (cyc - t0[k] == L);
        if (e_lng[k]) ldone[k] = 1;
        e_clk[k] = e_rel[k] && !ldone[k];
        m_lvl[k] = nl;
      end
      h2 = h1;
      h1 = b;
    end
    cyc++;
  endtask

  task automatic tick(input logic r, input logic [1:0] b);
    reset = r;
    i_btn = b;
    @(posedge clk);
    model_step(r, b);
    #1;
    check("model", {o_level, o_press, o_release, o_click, o_long},
          {m_lvl, e_prs, e_rel, e_clk, e_lng});
  endtask

  typedef struct {
    logic       rst;
    logic [1:0] btn;
    int         n;
    logic [1:0] lvl, prs, rel, clk_, lng;
  } vec_t;

  vec_t vec [12];

  initial begin
    int np, nl, nr, nrc, pc, lc, rcl, fp, fl;
    logic [1:0] lv;
    logic [1:0] pin;
    int rem [2];

    //             rst  btn    n  lvl    prs    rel    click  long
    vec[0]  = '{1'b1, 2'b00, 3, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
    vec[1]  = '{1'b0, 2'b00, 5, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
    vec[2]  = '{1'b0, 2'b00, 1, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00};
    vec[3]  = '{1'b0, 2'b00, 1, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00};
    vec[4]  = '{1'b0, 2'b11, 5, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00};
    vec[5]  = '{1'b0, 2'b11, 1, 2'b00, 2'b00, 2'b11, 2'b11, 2'b00};
    vec[6]  = '{1'b0, 2'b11, 1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
    vec[7]  = '{1'b0, 2'b10, 5, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
    vec[8]  = '{1'b0, 2'b10, 1, 2'b01, 2'b01, 2'b00, 2'b00, 2'b00};
    vec[9]  = '{1'b0, 2'b10, 1, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00};
    vec[10] = '{1'b0, 2'b11, 5, 2'b01, 2'b00, 2'b00, 2'b00, 2'b00};
    vec[11] = '{1'b0, 2'b11, 1, 2'b00, 2'b00, 2'b01, 2'b01, 2'b00};

    for (int i = 0; i < 12; i++) begin
      for (int j = 0; j < vec[i].n; j++) begin
        tick(vec[i].rst, vec[i].btn);
        if (vec[i].rst)
          check("reset_zero", {o_level, o_press, o_release, o_click, o_long}, 10'd0);
      end
      check("vec", {o_level, o_press, o_release, o_click, o_long},
            {vec[i].lvl, vec[i].prs, vec[i].rel, vec[i].clk_, vec[i].lng});
      $display("[TB] vec %0d rst=%b btn=%b n=%0d lvl=%b prs=%b rel=%b clk=%b lng=%b",
               i, vec[i].rst, vec[i].btn, vec[i].n, o_level, o_press, o_release, o_click, o_long);
    end

    // Glitch train: 3 low / 1 high never reaches the debounce threshold.
    for (int rep = 0; rep < 10; rep++) begin
      for (int j = 0; j < 4; j++) begin
        tick(1'b0, (j < 3) ? 2'b10 : 2'b11);
        check("glitch_quiet", {o_level[0], o_press[0], o_release[0], o_click[0], o_long[0]}, 10'd0);
      end
    end
    for (int j = 0; j < 6; j++) tick(1'b0, 2'b11);
    $display("[TB] glitch train done level=%b", o_level);

    // Short hold on button 0: click with release, no long.
    np = 0; nl = 0; nrc = 0;
    for (int j = 0; j < 26; j++) begin
      tick(1'b0, (j < 16) ? 2'b10 : 2'b11);
      np  += o_press[0];
      nl  += o_long[0];
      nrc += (o_release[0] && o_click[0]);
    end
    check("short_press_count", 10'(np), 10'd1);
    check("short_long_count", 10'(nl), 10'd0);
    check("short_release_click", 10'(nrc), 10'd1);
    $display("[TB] short hold presses=%0d longs=%0d release+click=%0d", np, nl, nrc);

    // Long hold on button 1: long exactly L after press, once; release without click.
    pc = -1; lc = -1; nl = 0; nr = 0; rcl = 0;
    for (int j = 0; j < 46; j++) begin
      tick(1'b0, (j < 36) ? 2'b01 : 2'b11);
      if (o_press[1]) pc = j;
      if (o_long[1]) begin lc = j; nl++; end
      if (o_release[1]) begin nr++; rcl += o_click[1]; end
    end
    check("long_delay", 10'(lc - pc), 10'(L));
    check("long_once", 10'(nl), 10'd1);
    check("long_release", 10'(nr), 10'd1);
    check("long_no_click", 10'(rcl), 10'd0);
    $display("[TB] long hold press@%0d long@%0d longs=%0d releases=%0d clicks=%0d", pc, lc, nl, nr, rcl);

    // Reset in the middle of a hold of both buttons.
    for (int j = 0; j < 6; j++) tick(1'b0, 2'b00);
    check("both_press", {8'd0, o_press}, 10'b11);
    for (int j = 0; j < 9; j++) tick(1'b0, 2'b00);
    tick(1'b1, 2'b00);
    check("midreset_zero", {o_level, o_press, o_release, o_click, o_long}, 10'd0);
    fp = -1; fl = -1; nl = 0; lv = 2'b00;
    for (int j = 1; j <= 30; j++) begin
      tick(1'b0, 2'b00);
      if (o_press != 0 && fp < 0) begin fp = j; lv = o_press; end
      if (o_long != 0) begin nl++; if (fl < 0) fl = j; end
    end
    check("repress_cycle", 10'(fp), 10'd6);
    check("repress_bits", {8'd0, lv}, 10'b11);
    check("relong_cycle", 10'(fl), 10'(6 + L));
    check("relong_count", 10'(nl), 10'd1);
    $display("[TB] mid-hold reset repress@%0d bits=%b long@%0d longs=%0d", fp, lv, fl, nl);
    for (int j = 0; j < 8; j++) tick(1'b0, 2'b11);

    // Random pin activity with occasional resets.
    pin = 2'b11; rem[0] = 0; rem[1] = 0;
    for (int burst = 0; burst < 8; burst++) begin
      int f0;
      f0 = fails;
      for (int j = 0; j < 500; j++) begin
        for (int k = 0; k < 2; k++) begin
          if (rem[k] == 0) begin
            pin[k] = 1'($urandom_range(0, 1));
            rem[k] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(20, 40))
                                                 : int'($urandom_range(1, 8));
          end
          rem[k]--;
        end
        tick($urandom_range(0, 299) == 0, pin);
      end
      $display("[TB] random burst %0d: %0d cycles, %0d new failures", burst, 500, fails - f0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
